spi8_mem_ctrl: RTL and testbench

Command sequencer and two-port arbiter for the octal-SPI DDR memory behind the `spi8ddr` pad block. It runs in the 192 MHz SPI8 clock domain and sits between two requesters (port 0: ADC sample logger, port 1: readback/display) and the 16-bit DDR pad interface, one byte per clock edge. It owns the memory reset pulse, the command/address framing, latency counting, data bursts and chip-select spacing.

---
 rtl/spi8_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_spi8_mem_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi8_mem_ctrl.sv
// Octal-SPI DDR command sequencer with a two-port round-robin arbiter.
// Frames command/address, counts latency, moves data bursts and spaces chip selects.
module spi8_mem_ctrl #(
    parameter int unsigned LAT_CYCLES = 6,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned RST_WAIT   = 64,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [3:0]  p0_len,
    output logic        p0_gnt,
    input  logic [15:0] p0_wdata,
    output logic        p0_wnext,
    output logic        p0_rvalid,
    output logic        p0_done,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [3:0]  p1_len,
    output logic        p1_gnt,
    input  logic [15:0] p1_wdata,
    output logic        p1_wnext,
    output logic        p1_rvalid,
    output logic        p1_done,
    output logic [15:0] rdata,
    output logic [15:0] spi_dout,
    input  logic [15:0] spi_din,
    output logic        spi_oe,
    output logic        spi_ncs,
    output logic        spi_nrst
);
    localparam int CW = 8;

    typedef enum logic [3:0] {
        S_RST_LO, S_RST_WAIT, S_IDLE, S_CMD0, S_CMD1, S_CMD2, S_LAT, S_DATA, S_GAP
    } state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic        port_q, we_q, last_q, rd_beat_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [1:0]  gnt_q, wnext_q, rvalid_q, done_q;
    logic [15:0] dout_q, rdata_q;
    logic        oe_q, ncs_q, nrst_q;

    logic [1:0]  req;
    logic        pick;
    logic [15:0] wdata_sel;
    logic [7:0]  opcode;

    assign req       = {p1_req, p0_req};
    assign pick      = (req == 2'b11) ? ~last_q : req[1];
    assign wdata_sel = port_q ? p1_wdata : p0_wdata;
    assign opcode    = we_q ? 8'hDE : 8'hEE;

    // The state register runs one clock ahead of the bus outputs: each bus
    // output is the registered decode of the state held in the previous clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RST_LO;
            cnt_q     <= '0;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            len_q     <= '0;
            rd_beat_q <= 1'b0;
            gnt_q     <= '0;
            wnext_q   <= '0;
            rvalid_q  <= '0;
            done_q    <= '0;
            dout_q    <= '0;
            rdata_q   <= '0;
            oe_q      <= 1'b0;
            ncs_q     <= 1'b1;
            nrst_q    <= 1'b0;
        end else begin
            gnt_q     <= '0;
            wnext_q   <= '0;
            done_q    <= '0;
            rvalid_q  <= '0;
            rd_beat_q <= 1'b0;
            ncs_q     <= 1'b1;
            oe_q      <= 1'b0;
            dout_q    <= '0;

            if (rd_beat_q) begin
                rdata_q          <= spi_din;
                rvalid_q[port_q] <= 1'b1;
            end

            case (state_q)
                S_RST_LO: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        nrst_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_RST_WAIT;
                    end
                end
                S_RST_WAIT: begin
                    // One short: the grant pulse itself is the first usable clock.
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == CW'(RST_WAIT - 2)) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (|req) begin
                        gnt_q[pick] <= 1'b1;
                        port_q      <= pick;
                        last_q      <= pick;
                        we_q        <= pick ? p1_we   : p0_we;
                        addr_q      <= pick ? p1_addr : p0_addr;
                        len_q       <= pick ? p1_len  : p0_len;
                        state_q     <= S_CMD0;
                    end
                end
                S_CMD0: begin
                    ncs_q   <= 1'b0;
                    oe_q    <= 1'b1;
                    dout_q  <= {opcode, addr_q[31:24]};
                    state_q <= S_CMD1;
                end
                S_CMD1: begin
                    ncs_q   <= 1'b0;
                    oe_q    <= 1'b1;
                    dout_q  <= addr_q[23:8];
                    state_q <= S_CMD2;
                end
                S_CMD2: begin
                    ncs_q   <= 1'b0;
                    oe_q    <= 1'b1;
                    dout_q  <= {addr_q[7:0], 8'h00};
                    cnt_q   <= '0;
                    state_q <= S_LAT;
                end
                S_LAT: begin
                    ncs_q           <= 1'b0;
                    wnext_q[port_q] <= we_q && (cnt_q == CW'(LAT_CYCLES - 1));
                    cnt_q           <= cnt_q + 8'd1;
                    if (cnt_q == CW'(LAT_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    ncs_q           <= 1'b0;
                    oe_q            <= we_q;
                    rd_beat_q       <= ~we_q;
                    wnext_q[port_q] <= we_q && (cnt_q < {4'd0, len_q});
                    if (we_q) begin
                        dout_q <= wdata_sel;
                    end
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == {4'd0, len_q}) begin
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    done_q[port_q] <= (cnt_q == '0);
                    cnt_q          <= cnt_q + 8'd1;
                    if (cnt_q == CW'(CS_GAP - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_RST_LO;
            endcase
        end
    end

    assign p0_gnt    = gnt_q[0];
    assign p1_gnt    = gnt_q[1];
    assign p0_wnext  = wnext_q[0];
    assign p1_wnext  = wnext_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_done   = done_q[0];
    assign p1_done   = done_q[1];
    assign rdata     = rdata_q;
    assign spi_dout  = dout_q;
    assign spi_oe    = oe_q;
    assign spi_ncs   = ncs_q;
    assign spi_nrst  = nrst_q;
endmodule

// File: tb/tb_spi8_mem_ctrl.sv
// Bench for spi8_mem_ctrl: random transactions checked clock by clock against
// a timeline model derived from the transaction parameters and round-robin rule.
module tb_spi8_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p1_addr;
    logic [3:0]  p0_len, p1_len;
    logic [15:0] p0_wdata, p1_wdata, spi_din;
    logic        p0_gnt, p0_wnext, p0_rvalid, p0_done;
    logic        p1_gnt, p1_wnext, p1_rvalid, p1_done;
    logic [15:0] rdata, spi_dout;
    logic        spi_oe, spi_ncs, spi_nrst;

    always #5 clk = ~clk;

    spi8_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_len(p0_len),
        .p0_gnt(p0_gnt), .p0_wdata(p0_wdata), .p0_wnext(p0_wnext),
        .p0_rvalid(p0_rvalid), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_len(p1_len),
        .p1_gnt(p1_gnt), .p1_wdata(p1_wdata), .p1_wnext(p1_wnext),
        .p1_rvalid(p1_rvalid), .p1_done(p1_done),
        .rdata(rdata), .spi_dout(spi_dout), .spi_din(spi_din),
        .spi_oe(spi_oe), .spi_ncs(spi_ncs), .spi_nrst(spi_nrst)
    );

    logic [1:0] gnt_v, wnext_v, rvalid_v, done_v;
    assign gnt_v    = {p1_gnt, p0_gnt};
    assign wnext_v  = {p1_wnext, p0_wnext};
    assign rvalid_v = {p1_rvalid, p0_rvalid};
    assign done_v   = {p1_done, p0_done};

    int          n_vec = 0;
    int          n_err = 0;
    logic        model_last;
    logic        din_fixed = 1'b0;
    logic [15:0] words [2][16];
    logic [15:0] din_buf [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic v);
        if (p == 0) p0_req = v; else p1_req = v;
    endtask

    task automatic load_port(input int p, input logic we, input logic [31:0] addr, input logic [3:0] len);
        for (int k = 0; k < 16; k++) words[p][k] = 16'($urandom);
        if (p == 0) begin
            p0_we = we; p0_addr = addr; p0_len = len; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_len = len; p1_req = 1'b1;
        end
    endtask

    task automatic reload(input int p, input int max_len);
        load_port(p, 1'($urandom), $urandom, 4'($urandom_range(0, max_len)));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
        model_last = 1'b1;
    endtask

    // Expected bus activity relative to the grant clock (i = 0).
    task automatic run_timeline(input int p, input int abort_at);
        logic        we;
        logic [31:0] addr;
        int          L;
        logic [15:0] cmd [3];
        logic [1:0]  ew, er, ed;
        int          bad;
        we   = (p == 0) ? p0_we : p1_we;
        addr = (p == 0) ? p0_addr : p1_addr;
        L    = int'((p == 0) ? p0_len : p1_len);
        cmd[0] = {(we ? 8'hDE : 8'hEE), addr[31:24]};
        cmd[1] = addr[23:8];
        cmd[2] = {addr[7:0], 8'h00};
        if (!din_fixed) for (int k = 0; k < 16; k++) din_buf[k] = 16'($urandom);
        $display("txn port=%0d we=%0d addr=%h len=%0d", p, we, addr, L);
        for (int i = 1; i <= 12 + L; i++) begin
            tick();
            ew = '0; er = '0; ed = '0;
            if (we && i >= 9 && i <= 9 + L) ew[p] = 1'b1;
            if (!we && i >= 11 && i <= 11 + L) er[p] = 1'b1;
            if (i == 11 + L) ed[p] = 1'b1;
            check("gnt_pulse", gnt_v, 0);
            check("ncs", spi_ncs, (i <= 10 + L) ? 0 : 1);
            check("oe", spi_oe, (i <= 3) ? 1 : ((i >= 10 && i <= 10 + L) ? we : 0));
            if (i <= 3) check("cmd_word", spi_dout, cmd[i-1]);
            if (we && i >= 10 && i <= 10 + L) check("wbeat", spi_dout, words[p][i-10]);
            check("wnext", wnext_v, ew);
            check("rvalid", rvalid_v, er);
            if (er != 2'b00) check("rdata", rdata, din_buf[i-11]);
            check("done", done_v, ed);
            if (i == abort_at) begin
                reset = 1'b1;
                tick();
                check("abort_ncs", spi_ncs, 1);
                check("abort_nrst", spi_nrst, 0);
                check("abort_done", done_v, 0);
                check("abort_rvalid", rvalid_v, 0);
                reset = 1'b0;
                model_last = 1'b1;
                bad = 0;
                repeat (30) begin
                    tick();
                    if (rvalid_v != 2'b00 || done_v != 2'b00 || spi_ncs !== 1'b1) bad++;
                end
                check("abort_quiet", bad, 0);
                return;
            end
            p0_wdata = 16'($urandom);
            p1_wdata = 16'($urandom);
            if (we && i >= 9 && i <= 9 + L) begin
                if (p == 0) p0_wdata = words[0][i-9]; else p1_wdata = words[1][i-9];
            end
            spi_din = (i >= 10 && i <= 10 + L) ? din_buf[i-10] : 16'($urandom);
        end
    endtask

    task automatic serve(input int exp_wait, input int abort_at, output int gp);
        int         w;
        int         exp_p;
        logic [1:0] rq;
        rq    = {p1_req, p0_req};
        exp_p = (rq == 2'b11) ? (model_last ? 0 : 1) : (rq[1] ? 1 : 0);
        gp    = exp_p;
        w     = 0;
        do begin
            tick();
            w++;
        end while (gnt_v == 2'b00 && w < 300);
        check("gnt_port", gnt_v, 2'b01 << exp_p);
        if (gnt_v == 2'b00) return;
        if (exp_wait > 0) check("gnt_latency", w, exp_wait);
        model_last = exp_p[0];
        set_req(exp_p, 1'b0);
        run_timeline(exp_p, abort_at);
    endtask

    initial begin
        int nlow, w, ncs_bad, gp;
        reset = 1'b1;
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_addr = 0; p1_addr = 0; p0_len = 0; p1_len = 0;
        p0_wdata = 0; p1_wdata = 0; spi_din = 0;
        model_last = 1'b1;
        repeat (3) @(posedge clk);
        tick();
        check("rst_nrst", spi_nrst, 0);
        check("rst_ncs", spi_ncs, 1);
        check("rst_oe", spi_oe, 0);
        check("rst_dout", spi_dout, 0);
        check("rst_rdata", rdata, 0);
        check("rst_strobes", {gnt_v, wnext_v, rvalid_v, done_v}, 0);
        reset = 1'b0;

        // Reset sequence followed by a single write on port 0.
        load_port(0, 1'b1, 32'h0001_2345, 4'd0);
        words[0][0] = 16'hBEEF;
        nlow = 0; ncs_bad = 0;
        while (spi_nrst == 1'b0 && nlow < 100) begin
            nlow++;
            if (spi_ncs !== 1'b1) ncs_bad++;
            tick();
        end
        check("nrst_low_clocks", nlow, 16);
        w = 0;
        while (p0_gnt !== 1'b1 && w < 200) begin
            if (spi_ncs !== 1'b1) ncs_bad++;
            tick();
            w++;
        end
        check("first_gnt_delay", w, 64);
        check("ncs_during_reset", ncs_bad, 0);
        model_last = 1'b0;
        p0_req = 1'b0;
        run_timeline(0, 0);

        // Single read on port 1, issued back to back.
        for (int k = 0; k < 16; k++) din_buf[k] = 16'(k + 1);
        din_fixed = 1'b1;
        load_port(1, 1'b0, 32'h0, 4'd3);
        serve(1, 0, gp);
        din_fixed = 1'b0;

        // Maximum burst write.
        load_port(0, 1'b1, $urandom, 4'd15);
        serve(1, 0, gp);

        // Arbitration with both ports requesting, then port 1 alone, then a tie.
        do_reset(2);
        reload(0, 3);
        reload(1, 3);
        serve(0, 0, gp); reload(gp, 3);
        serve(1, 0, gp); reload(gp, 3);
        serve(1, 0, gp); reload(gp, 3);
        serve(1, 0, gp); reload(1, 3); set_req(0, 1'b0);
        serve(1, 0, gp); reload(1, 3);
        serve(1, 0, gp); reload(1, 3); reload(0, 3);
        serve(1, 0, gp);

        // Random traffic.
        for (int k = 0; k < 8; k++) begin
            if (!p0_req && ($urandom % 2 == 1)) reload(0, 15);
            if (!p1_req && ($urandom % 2 == 1)) reload(1, 15);
            if (!p0_req && !p1_req) reload(int'($urandom % 2), 15);
            serve(1, 0, gp);
        end

        // Reset during the third read beat.
        p0_req = 1'b0;
        p1_req = 1'b0;
        load_port(1, 1'b0, $urandom, 4'd7);
        serve(1, 12, gp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
